// File: rtl/uart_tx_arbiter.sv
// Line-granular round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional stalled-lock revocation is built when TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4_000_000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ*8-1:0]   char_in,
    input  logic [NUM_REQ-1:0]     char_valid_in,
    output logic [NUM_REQ-1:0]     char_ready_out,
    output logic [7:0]             tx_char_out,
    output logic                   tx_trigger_out,
    input  logic                   tx_busy_in,
    output logic [NUM_REQ-1:0]     grant_out,
    output logic                   timeout_out
);

    localparam int unsigned PtrW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2) begin : gen_bad_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {StIdle, StOwn, StSend, StGap, StDrain} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [7:0]      tx_char_q, tx_char_d;
    logic            eol_q, eol_d;

    logic [PtrW-1:0] owner_next;
    logic [PtrW-1:0] pick_idx, pick_hi, pick_any;
    logic            found_hi;
    logic            owner_valid;
    logic [7:0]      owner_char;
    logic            expire;

    assign owner_valid = char_valid_in[owner_q];
    assign owner_char  = char_in[{owner_q, 3'b000} +: 8];
    assign owner_next  = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Winner: lowest valid index >= rr_ptr, else lowest valid index overall (wrap).
    always_comb begin
        pick_hi  = '0;
        pick_any = '0;
        found_hi = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (char_valid_in[j]) begin
                pick_any = PtrW'(j);
                if (PtrW'(j) >= rr_ptr_q) begin
                    pick_hi  = PtrW'(j);
                    found_hi = 1'b1;
                end
            end
        end
        pick_idx = found_hi ? pick_hi : pick_any;
    end

`ifdef TX_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q;

    always_comb begin
        expire = 1'b0;
        if (state_q == StOwn && !owner_valid && cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            expire = 1'b1;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (state_q == StOwn && !owner_valid && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= expire;
        end
    end

    assign timeout_out = timeout_q;
`else
    assign expire      = 1'b0;
    assign timeout_out = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        tx_char_d      = tx_char_q;
        eol_d          = eol_q;
        char_ready_out = '0;
        grant_out      = '0;
        tx_trigger_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|char_valid_in) begin
                    owner_d = pick_idx;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                grant_out[owner_q]      = 1'b1;
                char_ready_out[owner_q] = !tx_busy_in;
                if (owner_valid && !tx_busy_in) begin
                    tx_char_d = owner_char;
                    eol_d     = (owner_char == 8'h0A);
                    state_d   = StSend;
                end else if (expire) begin
                    rr_ptr_d = owner_next;
                    state_d  = StIdle;
                end
            end
            StSend: begin
                grant_out[owner_q] = 1'b1;
                tx_trigger_out     = 1'b1;
                state_d            = StGap;
            end
            // Transmitter busy lags the trigger by a cycle, so it is not trusted here.
            StGap: begin
                grant_out[owner_q] = 1'b1;
                state_d            = StDrain;
            end
            StDrain: begin
                grant_out[owner_q] = 1'b1;
                if (!tx_busy_in) begin
                    if (eol_q) begin
                        rr_ptr_d = owner_next;
                        state_d  = StIdle;
                    end else begin
                        state_d = StOwn;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            tx_char_q <= 8'h00;
            eol_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            tx_char_q <= tx_char_d;
            eol_q     <= eol_d;
        end
    end

    assign tx_char_out = tx_char_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among several byte-stream requesters: UCI command responses, engine `info` lines and debug output. Arbitration is line-granular, so lines never interleave. A requester is granted round-robin, holds the grant until it sends a newline (0x0A), and gets one byte accepted per transmitter frame. The block sits between the requesters and `uart_transmit` on the 40 MHz clock. It drives the transmitter's `data_byte_in`/`trigger_in` and observes `busy_out`.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters. Must be ≥ 2.
- `TIMEOUT_CYCLES`, default 4_000_000: idle cycles before a stalled lock is revoked. Used only with `TX_ARB_TIMEOUT_EN`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous active-high reset.
- `char_in` input `NUM_REQ*8`: requester i byte at `[8i+7:8i]`.
- `char_valid_in` input `NUM_REQ`: requester i has a byte.
- `char_ready_out` output `NUM_REQ`: byte i accepted when valid and ready are both high.
- `tx_char_out` output 8: byte to the transmitter `data_byte_in`.
- `tx_trigger_out` output 1: one-cycle pulse to `trigger_in`.
- `tx_busy_in` input 1: transmitter `busy_out`.
- `grant_out` output `NUM_REQ`: one-hot current owner; all zero when unlocked.
- `timeout_out` output 1: one-cycle pulse when a lock is revoked.

## Operation
States:
- **IDLE**
  - No owner; `grant_out` = 0.
  - If any `char_valid_in` is high, pick the first valid index at or after `rr_ptr`, wrapping modulo `NUM_REQ`. Set `grant_out` to that index and go to OWN.
  - No byte is accepted in IDLE.
- **OWN**
  - `char_ready_out[owner]` = `tx_busy_in` == 0. Computed combinationally; independent of valid. All other ready bits are 0.
  - On accept: latch the byte into `tx_char_out`. Set `eol` = (byte == 0x0A). Go to SEND.
- **SEND**
  - `tx_trigger_out` = 1 for exactly this cycle. Go to GAP.
- **GAP**
  - One cycle. `tx_busy_in` is ignored here, covering the transmitter's busy-rise latency. Go to DRAIN.
- **DRAIN**
  - Wait while `tx_busy_in` = 1.
  - When it is 0 and `eol` = 1: set `rr_ptr` to (owner+1) mod `NUM_REQ`, clear the grant and go to IDLE.
  - When it is 0 and `eol` = 0: go to OWN.

Rules:
- Non-owner requesters never see ready, even while the owner is idle.
- `rr_ptr` width is max(1, $clog2(`NUM_REQ`)). Wrap is explicit: owner `NUM_REQ`-1 → 0.
- `tx_char_out` holds its value from accept until the next accept.
- Reset mid-frame: the transmitter finishes its frame on its own. After reset the arbiter is in IDLE. Any requester granted afterwards waits in OWN until `tx_busy_in` falls.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_out` 0, `char_ready_out` 0, `tx_char_out` 0x00, `tx_trigger_out` 0, `timeout_out` 0, `eol` 0, timeout counter 0.
- Grant latency: valid high in IDLE at cycle t → `grant_out` at t+1 → ready possible at t+1.
- Accept at cycle t → `tx_trigger_out` at t+1 → earliest next accept at t+4, once busy has dropped.
- Simultaneous requests: the round-robin winner is taken. Losers hold valid until they are granted; no byte is lost.
- Owner drops valid mid-line: the lock is held and the block stays in OWN (subject to the timeout).
- A newline as the first byte of a line is legal: a one-byte line, released after its drain.

## Configuration
- `TX_ARB_TIMEOUT_EN` defined:
  - In OWN, a counter of width $clog2(`TIMEOUT_CYCLES`+1) increments each cycle the owner's valid is low. It resets to 0 on any owner valid and on leaving OWN.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout_out`, set `rr_ptr` to owner+1, clear the grant and go to IDLE.
- Not defined: no counter is built, `timeout_out` is tied to 0, and the lock is held indefinitely.

## Test plan
- After reset with `tx_busy_in`=0: all outputs match the reset values. Requester 1 sends "ok\n" → `tx_char_out` sequence 0x6F, 0x6B, 0x0A, one trigger each, `grant_out` 0b010 throughout, then 0.
- Requesters 0 and 2 each stream a line ending in 0x0A, valid simultaneously, with `rr_ptr`=0 → requester 0's bytes are all sent before any of requester 2's. `rr_ptr` is then 1. With requester 0 still requesting, the next grant goes to 2, not 0.
- Hold `tx_busy_in` high for 3470 cycles after each trigger → exactly one trigger per frame; no ready during GAP or DRAIN.
- Owner 1 stops mid-line ("in" with no 0x0A) with `TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100 → `timeout_out` pulses after 100 idle cycles and requester 2 is granted next. With the macro off → the grant stays 0b010 forever.
- Assert `rst_in` during DRAIN with `tx_busy_in`=1 → IDLE and zeroed outputs on the next cycle. The first post-reset accept waits until `tx_busy_in`=0.
- `NUM_REQ`=3, owner 2 ends a line → `rr_ptr` wraps to 0.
